eth_tx_frame_arbiter: RTL

//  Shares one 8-bit Ethernet frame TX port (header + AXI-stream payload) between S_COUNT frame sources,
//  e.g. the IP TX path and an ARP TX path, in front of the Ethernet MAC framer.

---
 rtl/eth_tx_frame_arbiter.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-granular arbiter sharing one Ethernet header + AXI-stream payload TX port among S_COUNT sources.
// A source keeps the port from its header handshake through its tlast beat; fixed priority or round robin.
module eth_tx_frame_arbiter #(
  parameter int S_COUNT         = 2,
  parameter int ARB_ROUND_ROBIN = 0,
  parameter int ARB_LSB_HIGH    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [S_COUNT-1:0]      s_eth_hdr_valid,
  output logic [S_COUNT-1:0]      s_eth_hdr_ready,
  input  logic [48*S_COUNT-1:0]   s_eth_dest_mac,
  input  logic [48*S_COUNT-1:0]   s_eth_src_mac,
  input  logic [16*S_COUNT-1:0]   s_eth_type,
  input  logic [8*S_COUNT-1:0]    s_eth_payload_axis_tdata,
  input  logic [S_COUNT-1:0]      s_eth_payload_axis_tvalid,
  output logic [S_COUNT-1:0]      s_eth_payload_axis_tready,
  input  logic [S_COUNT-1:0]      s_eth_payload_axis_tlast,
  input  logic [S_COUNT-1:0]      s_eth_payload_axis_tuser,
  output logic                    m_eth_hdr_valid,
  input  logic                    m_eth_hdr_ready,
  output logic [47:0]             m_eth_dest_mac,
  output logic [47:0]             m_eth_src_mac,
  output logic [15:0]             m_eth_type,
  output logic [7:0]              m_eth_payload_axis_tdata,
  output logic                    m_eth_payload_axis_tvalid,
  input  logic                    m_eth_payload_axis_tready,
  output logic                    m_eth_payload_axis_tlast,
  output logic                    m_eth_payload_axis_tuser,
  output logic                    grant_valid,
  output logic [2:0]              grant_index
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [2:0]  r_grant_index;
  logic [2:0]  r_rr_ptr;
  logic        r_hdr_valid;
  logic [47:0] r_dest_mac;
  logic [47:0] r_src_mac;
  logic [15:0] r_type;

  logic        w_any_req;
  logic [2:0]  w_low_idx;
  logic [2:0]  w_high_idx;
  logic [2:0]  w_rr_idx;
  logic        w_rr_hit;
  logic [2:0]  w_winner;
  logic [47:0] w_sel_dest;
  logic [47:0] w_sel_src;
  logic [15:0] w_sel_type;
  logic        w_last_beat;

  // Descending scan: the last hit is the lowest requester, the first hit the highest;
  // round robin takes the lowest requester at or above the pointer, else wraps to the lowest.
  always_comb begin
    w_any_req  = 1'b0;
    w_low_idx  = 3'd0;
    w_high_idx = 3'd0;
    w_rr_idx   = 3'd0;
    w_rr_hit   = 1'b0;
    for (int i = S_COUNT - 1; i >= 0; i--) begin
      if (s_eth_hdr_valid[i]) begin
        if (!w_any_req) begin
          w_high_idx = 3'(i);
        end else begin
          w_high_idx = w_high_idx;
        end
        w_any_req = 1'b1;
        w_low_idx = 3'(i);
        if (3'(i) >= r_rr_ptr) begin
          w_rr_idx = 3'(i);
          w_rr_hit = 1'b1;
        end else begin
          w_rr_idx = w_rr_idx;
        end
      end else begin
        w_any_req = w_any_req;
      end
    end
    if (ARB_ROUND_ROBIN != 0) begin
      w_winner = w_rr_hit ? w_rr_idx : w_low_idx;
    end else if (ARB_LSB_HIGH != 0) begin
      w_winner = w_low_idx;
    end else begin
      w_winner = w_high_idx;
    end
  end

  // Header fields of the current arbitration winner.
  always_comb begin
    w_sel_dest = 48'd0;
    w_sel_src  = 48'd0;
    w_sel_type = 16'd0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (w_winner == 3'(i)) begin
        w_sel_dest = s_eth_dest_mac[48*i +: 48];
        w_sel_src  = s_eth_src_mac[48*i +: 48];
        w_sel_type = s_eth_type[16*i +: 16];
      end else begin
        w_sel_type = w_sel_type;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) w_state_next = ST_HDR;
        else           w_state_next = ST_IDLE;
      end
      ST_HDR: begin
        if (m_eth_hdr_ready) w_state_next = ST_PAYLOAD;
        else                 w_state_next = ST_HDR;
      end
      ST_PAYLOAD: begin
        if (w_last_beat) w_state_next = ST_IDLE;
        else             w_state_next = ST_PAYLOAD;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Outputs: header ready only in IDLE, zero-latency payload pass-through only in PAYLOAD.
  always_comb begin
    s_eth_hdr_ready           = {S_COUNT{1'b0}};
    s_eth_payload_axis_tready = {S_COUNT{1'b0}};
    m_eth_payload_axis_tdata  = 8'd0;
    m_eth_payload_axis_tvalid = 1'b0;
    m_eth_payload_axis_tlast  = 1'b0;
    m_eth_payload_axis_tuser  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        for (int i = 0; i < S_COUNT; i++) begin
          s_eth_hdr_ready[i] = w_any_req && (w_winner == 3'(i));
        end
      end
      ST_PAYLOAD: begin
        for (int i = 0; i < S_COUNT; i++) begin
          if (r_grant_index == 3'(i)) begin
            m_eth_payload_axis_tdata     = s_eth_payload_axis_tdata[8*i +: 8];
            m_eth_payload_axis_tvalid    = s_eth_payload_axis_tvalid[i];
            m_eth_payload_axis_tlast     = s_eth_payload_axis_tlast[i];
            m_eth_payload_axis_tuser     = s_eth_payload_axis_tuser[i];
            s_eth_payload_axis_tready[i] = m_eth_payload_axis_tready;
          end else begin
            s_eth_payload_axis_tready[i] = 1'b0;
          end
        end
      end
      default: begin
        s_eth_hdr_ready = {S_COUNT{1'b0}};
      end
    endcase
    w_last_beat = m_eth_payload_axis_tvalid && m_eth_payload_axis_tready && m_eth_payload_axis_tlast;
  end

  // Header latch, grant bookkeeping and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hdr_valid   <= 1'b0;
      r_dest_mac    <= 48'd0;
      r_src_mac     <= 48'd0;
      r_type        <= 16'd0;
      r_grant_index <= 3'd0;
      r_rr_ptr      <= 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_hdr_valid   <= 1'b1;
            r_dest_mac    <= w_sel_dest;
            r_src_mac     <= w_sel_src;
            r_type        <= w_sel_type;
            r_grant_index <= w_winner;
          end
        end
        ST_HDR: begin
          if (m_eth_hdr_ready) r_hdr_valid <= 1'b0;
        end
        ST_PAYLOAD: begin
          if (w_last_beat && (ARB_ROUND_ROBIN != 0)) begin
            if (r_grant_index == 3'(S_COUNT - 1)) r_rr_ptr <= 3'd0;
            else                                   r_rr_ptr <= r_grant_index + 3'd1;
          end
        end
        default: r_hdr_valid <= 1'b0;
      endcase
    end
  end

  assign m_eth_hdr_valid = r_hdr_valid;
  assign m_eth_dest_mac  = r_dest_mac;
  assign m_eth_src_mac   = r_src_mac;
  assign m_eth_type      = r_type;
  assign grant_valid     = (r_state != ST_IDLE);
  assign grant_index     = r_grant_index;

endmodule
